// File: rtl/wb_arbiter.sv
// Writeback arbiter: one small FIFO per FU lane, drained onto N_WB registered
// writeback ports each cycle with round-robin fairness across lanes.
module wb_arbiter #(
    parameter int N_IN  = 7,
    parameter int N_WB  = 4,
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int PRF_W = 6,
    parameter int ROB_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_flush,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*PRF_W-1:0] in_prn,
    input  logic [N_IN*XLEN-1:0]  in_data,
    input  logic [N_IN*ROB_W-1:0] in_rob,
    output logic [N_IN-1:0]       lane_stall,
    output logic [N_WB-1:0]       wb_valid,
    output logic [N_WB-1:0]       wb_prf_we,
    output logic [N_WB*PRF_W-1:0] wb_prn,
    output logic [N_WB*XLEN-1:0]  wb_data,
    output logic [N_WB*ROB_W-1:0] wb_rob,
    output logic                  overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [PRF_W-1:0] memPrn_q  [N_IN][DEPTH];
    logic [XLEN-1:0]  memData_q [N_IN][DEPTH];
    logic [ROB_W-1:0] memRob_q  [N_IN][DEPTH];

    logic [CW-1:0]    count_q [N_IN];
    logic [CW-1:0]    count_d [N_IN];
    logic [PW-1:0]    wptr_q  [N_IN];
    logic [PW-1:0]    wptr_d  [N_IN];
    logic [PW-1:0]    rptr_q  [N_IN];
    logic [PW-1:0]    rptr_d  [N_IN];
    logic [RW-1:0]    rrPtr_q;
    logic [RW-1:0]    rrPtr_d;
    logic             overflow_q;
    logic             overflow_d;

    logic [N_IN-1:0]  grant;
    logic [N_IN-1:0]  pushOk;
    logic [N_WB-1:0]  portValid;
    logic [RW-1:0]    portLane [N_WB];

    logic [N_WB-1:0]  wbValid_q;
    logic [N_WB-1:0]  wbValid_d;
    logic [N_WB-1:0]  wbPrfWe_q;
    logic [N_WB-1:0]  wbPrfWe_d;
    logic [PRF_W-1:0] wbPrn_q  [N_WB];
    logic [PRF_W-1:0] wbPrn_d  [N_WB];
    logic [XLEN-1:0]  wbData_q [N_WB];
    logic [XLEN-1:0]  wbData_d [N_WB];
    logic [ROB_W-1:0] wbRob_q  [N_WB];
    logic [ROB_W-1:0] wbRob_d  [N_WB];

    // Scan lanes starting at rrPtr; the first N_WB non-empty heads win ports in scan order.
    always_comb begin
        int lane;
        int nGrant;
        lane      = 0;
        nGrant    = 0;
        grant     = '0;
        portValid = '0;
        rrPtr_d   = rrPtr_q;
        for (int k = 0; k < N_WB; k++) begin
            portLane[k] = '0;
        end
        for (int off = 0; off < N_IN; off++) begin
            lane = int'(rrPtr_q) + off;
            if (lane >= N_IN) begin
                lane = lane - N_IN;
            end
            if ((count_q[lane] != '0) && (nGrant < N_WB)) begin
                grant[lane]       = 1'b1;
                portValid[nGrant] = 1'b1;
                portLane[nGrant]  = RW'(lane);
                rrPtr_d           = (lane == N_IN - 1) ? '0 : RW'(lane + 1);
                nGrant            = nGrant + 1;
            end
        end
    end

    // A full FIFO still accepts a push when its head pops in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        pushOk     = '0;
        for (int i = 0; i < N_IN; i++) begin
            count_d[i] = count_q[i];
            wptr_d[i]  = wptr_q[i];
            rptr_d[i]  = rptr_q[i];
            if (pipe_flush) begin
                count_d[i] = '0;
                wptr_d[i]  = '0;
                rptr_d[i]  = '0;
            end else begin
                pushOk[i] = in_valid[i] && ((count_q[i] != CW'(DEPTH)) || grant[i]);
                if (in_valid[i] && !pushOk[i]) begin
                    overflow_d = 1'b1;
                end
                if (pushOk[i]) begin
                    wptr_d[i] = wptr_q[i] + PW'(1);
                end
                if (grant[i]) begin
                    rptr_d[i] = rptr_q[i] + PW'(1);
                end
                if (pushOk[i] && !grant[i]) begin
                    count_d[i] = count_q[i] + CW'(1);
                end else if (!pushOk[i] && grant[i]) begin
                    count_d[i] = count_q[i] - CW'(1);
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_WB; k++) begin
            wbValid_d[k] = portValid[k] && !pipe_flush;
            wbPrn_d[k]   = '0;
            wbData_d[k]  = '0;
            wbRob_d[k]   = '0;
            if (wbValid_d[k]) begin
                wbPrn_d[k]  = memPrn_q[portLane[k]][rptr_q[portLane[k]]];
                wbData_d[k] = memData_q[portLane[k]][rptr_q[portLane[k]]];
                wbRob_d[k]  = memRob_q[portLane[k]][rptr_q[portLane[k]]];
            end
            wbPrfWe_d[k] = wbValid_d[k] && (wbPrn_d[k] != '0);
        end
    end

    // FIFO payload needs no reset; the counts decide what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_IN; i++) begin
            if (pushOk[i]) begin
                memPrn_q[i][wptr_q[i]]  <= in_prn[i*PRF_W +: PRF_W];
                memData_q[i][wptr_q[i]] <= in_data[i*XLEN +: XLEN];
                memRob_q[i][wptr_q[i]]  <= in_rob[i*ROB_W +: ROB_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr_q    <= '0;
            overflow_q <= 1'b0;
            wbValid_q  <= '0;
            wbPrfWe_q  <= '0;
            for (int i = 0; i < N_IN; i++) begin
                count_q[i] <= '0;
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
            end
            for (int k = 0; k < N_WB; k++) begin
                wbPrn_q[k]  <= '0;
                wbData_q[k] <= '0;
                wbRob_q[k]  <= '0;
            end
        end else begin
            rrPtr_q    <= pipe_flush ? '0 : rrPtr_d;
            overflow_q <= overflow_d;
            wbValid_q  <= wbValid_d;
            wbPrfWe_q  <= wbPrfWe_d;
            for (int i = 0; i < N_IN; i++) begin
                count_q[i] <= count_d[i];
                wptr_q[i]  <= wptr_d[i];
                rptr_q[i]  <= rptr_d[i];
            end
            for (int k = 0; k < N_WB; k++) begin
                wbPrn_q[k]  <= wbPrn_d[k];
                wbData_q[k] <= wbData_d[k];
                wbRob_q[k]  <= wbRob_d[k];
            end
        end
    end

    // One entry of slack above the stall threshold covers a result already in flight.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            lane_stall[i] = (count_q[i] >= CW'(DEPTH - 1));
        end
    end

    always_comb begin
        for (int k = 0; k < N_WB; k++) begin
            wb_prn[k*PRF_W +: PRF_W] = wbPrn_q[k];
            wb_data[k*XLEN +: XLEN]  = wbData_q[k];
            wb_rob[k*ROB_W +: ROB_W] = wbRob_q[k];
        end
    end

    assign wb_valid  = wbValid_q;
    assign wb_prf_we = wbPrfWe_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a 4-port instance for the main scenarios and a
// 1-port instance sharing the same inputs for backpressure and overflow.
module tb_wb_arbiter;
    logic         clk;
    logic         rst_n;
    logic         pipe_flush;
    logic [6:0]   in_valid;
    logic [41:0]  in_prn;
    logic [223:0] in_data;
    logic [34:0]  in_rob;

    logic [6:0]   lane_stall;
    logic [3:0]   wb_valid;
    logic [3:0]   wb_prf_we;
    logic [23:0]  wb_prn;
    logic [127:0] wb_data;
    logic [19:0]  wb_rob;
    logic         overflow;

    logic [6:0]   lane_stall1;
    logic         wb_valid1;
    logic         wb_prf_we1;
    logic [5:0]   wb_prn1;
    logic [31:0]  wb_data1;
    logic [4:0]   wb_rob1;
    logic         overflow1;

    int checks = 0;
    int failures = 0;

    wb_arbiter #(.N_IN(7), .N_WB(4), .DEPTH(4), .XLEN(32), .PRF_W(6), .ROB_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
        .in_valid(in_valid), .in_prn(in_prn), .in_data(in_data), .in_rob(in_rob),
        .lane_stall(lane_stall), .wb_valid(wb_valid), .wb_prf_we(wb_prf_we),
        .wb_prn(wb_prn), .wb_data(wb_data), .wb_rob(wb_rob), .overflow(overflow)
    );

    wb_arbiter #(.N_IN(7), .N_WB(1), .DEPTH(4), .XLEN(32), .PRF_W(6), .ROB_W(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
        .in_valid(in_valid), .in_prn(in_prn), .in_data(in_data), .in_rob(in_rob),
        .lane_stall(lane_stall1), .wb_valid(wb_valid1), .wb_prf_we(wb_prf_we1),
        .wb_prn(wb_prn1), .wb_data(wb_data1), .wb_rob(wb_rob1), .overflow(overflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        in_valid = '0;
        in_prn   = '0;
        in_data  = '0;
        in_rob   = '0;
    endtask

    task automatic applyStimulus(input int lane, input logic [5:0] prn,
                                 input logic [31:0] data, input logic [4:0] rob);
        in_valid[lane]        = 1'b1;
        in_prn[lane*6 +: 6]   = prn;
        in_data[lane*32 +: 32] = data;
        in_rob[lane*5 +: 5]   = rob;
    endtask

    task automatic doReset();
        rst_n      = 1'b0;
        pipe_flush = 1'b0;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if ({wb_valid, wb_prf_we, lane_stall, overflow} !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%h want=0", {wb_valid, wb_prf_we, lane_stall, overflow});
        end
        checks++;
        if ({wb_prn, wb_data, wb_rob} !== 172'h0) begin
            failures++;
            $display("[TB] FAIL reset_payload got=%h want=0", {wb_prn, wb_data, wb_rob});
        end
        checks++;
        if ({wb_valid1, overflow1, lane_stall1} !== 9'h0) begin
            failures++;
            $display("[TB] FAIL reset_dut1 got=%h want=0", {wb_valid1, overflow1, lane_stall1});
        end
    endtask

    task automatic test_single();
        doReset();
        applyStimulus(0, 6'd5, 32'h1234, 5'd3);
        tick();
        clearInputs();
        checks++;
        if (wb_valid !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL single_early got=%b want=0000", wb_valid);
        end
        tick();
        checks++;
        if ({wb_valid, wb_prf_we} !== 8'b0001_0001) begin
            failures++;
            $display("[TB] FAIL single_valid got=%b want=00010001", {wb_valid, wb_prf_we});
        end
        checks++;
        if ({wb_prn[5:0], wb_data[31:0], wb_rob[4:0]} !== {6'd5, 32'h1234, 5'd3}) begin
            failures++;
            $display("[TB] FAIL single_payload got=%h want=%h", {wb_prn[5:0], wb_data[31:0], wb_rob[4:0]},
                     {6'd5, 32'h1234, 5'd3});
        end
        tick();
        checks++;
        if (wb_valid !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL single_after got=%b want=0000", wb_valid);
        end
    endtask

    task automatic test_contention();
        doReset();
        for (int l = 0; l < 7; l++) begin
            applyStimulus(l, 6'(l + 1), 32'h100 + 32'(l), 5'(l + 10));
        end
        tick();
        clearInputs();
        tick();
        checks++;
        if (wb_valid !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL cont_valid0 got=%b want=1111", wb_valid);
        end
        checks++;
        if (wb_data !== {32'h103, 32'h102, 32'h101, 32'h100}) begin
            failures++;
            $display("[TB] FAIL cont_data0 got=%h want=%h", wb_data, {32'h103, 32'h102, 32'h101, 32'h100});
        end
        checks++;
        if (wb_rob !== {5'd13, 5'd12, 5'd11, 5'd10}) begin
            failures++;
            $display("[TB] FAIL cont_rob0 got=%h want=%h", wb_rob, {5'd13, 5'd12, 5'd11, 5'd10});
        end
        tick();
        checks++;
        if (wb_valid !== 4'b0111) begin
            failures++;
            $display("[TB] FAIL cont_valid1 got=%b want=0111", wb_valid);
        end
        checks++;
        if (wb_data[95:0] !== {32'h106, 32'h105, 32'h104}) begin
            failures++;
            $display("[TB] FAIL cont_data1 got=%h want=%h", wb_data[95:0], {32'h106, 32'h105, 32'h104});
        end
        tick();
        checks++;
        if (wb_valid !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL cont_idle got=%b want=0000", wb_valid);
        end
        // With the pointer back at 0, lane 0 must beat lane 6 to port 0
        applyStimulus(6, 6'd1, 32'h606, 5'd1);
        applyStimulus(0, 6'd1, 32'h600, 5'd1);
        tick();
        clearInputs();
        tick();
        checks++;
        if ({wb_valid, wb_data[63:0]} !== {4'b0011, 32'h606, 32'h600}) begin
            failures++;
            $display("[TB] FAIL cont_rrptr got=%h want=%h", {wb_valid, wb_data[63:0]}, {4'b0011, 32'h606, 32'h600});
        end
    endtask

    task automatic test_zero_prn();
        doReset();
        applyStimulus(6, 6'd0, 32'hBEEF, 5'd9);
        tick();
        clearInputs();
        tick();
        checks++;
        if ({wb_valid, wb_prf_we} !== 8'b0001_0000) begin
            failures++;
            $display("[TB] FAIL zero_prn_we got=%b want=00010000", {wb_valid, wb_prf_we});
        end
        checks++;
        if ({wb_rob[4:0], wb_data[31:0]} !== {5'd9, 32'hBEEF}) begin
            failures++;
            $display("[TB] FAIL zero_prn_payload got=%h want=%h", {wb_rob[4:0], wb_data[31:0]}, {5'd9, 32'hBEEF});
        end
    endtask

    task automatic test_flush();
        doReset();
        for (int l = 0; l < 3; l++) applyStimulus(l, 6'd2, 32'h200 + 32'(l), 5'd1);
        tick();
        for (int l = 0; l < 3; l++) applyStimulus(l, 6'd2, 32'h210 + 32'(l), 5'd1);
        tick();
        checks++;
        if (wb_valid !== 4'b0111) begin
            failures++;
            $display("[TB] FAIL flush_pre got=%b want=0111", wb_valid);
        end
        pipe_flush = 1'b1;
        for (int l = 0; l < 3; l++) applyStimulus(l, 6'd2, 32'h220 + 32'(l), 5'd1);
        tick();
        pipe_flush = 1'b0;
        clearInputs();
        checks++;
        if ({wb_valid, wb_prf_we, lane_stall} !== 15'h0) begin
            failures++;
            $display("[TB] FAIL flush_clear got=%h want=0", {wb_valid, wb_prf_we, lane_stall});
        end
        tick();
        checks++;
        if (wb_valid !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL flush_empty got=%b want=0000", wb_valid);
        end
        applyStimulus(2, 6'd7, 32'hABCD, 5'd4);
        tick();
        clearInputs();
        tick();
        checks++;
        if ({wb_valid, wb_data[31:0]} !== {4'b0001, 32'hABCD}) begin
            failures++;
            $display("[TB] FAIL flush_repush got=%h want=%h", {wb_valid, wb_data[31:0]}, {4'b0001, 32'hABCD});
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] drainExp [8];
        drainExp = '{32'h104, 32'h005, 32'h105, 32'h006, 32'h106, 32'h007, 32'h107, 32'h008};
        doReset();
        for (int j = 1; j <= 8; j++) begin
            applyStimulus(0, 6'd1, 32'(j), 5'd0);
            applyStimulus(1, 6'd1, 32'h100 + 32'(j), 5'd0);
            tick();
            checks++;
            if ({lane_stall1[0], overflow1} !== {(j >= 5) ? 1'b1 : 1'b0, (j == 8) ? 1'b1 : 1'b0}) begin
                failures++;
                $display("[TB] FAIL bp_stall_ovf cycle=%0d got=%b%b want=%b%b", j, lane_stall1[0], overflow1,
                         (j >= 5) ? 1'b1 : 1'b0, (j == 8) ? 1'b1 : 1'b0);
            end
        end
        clearInputs();
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({wb_valid1, wb_data1} !== {1'b1, drainExp[k]}) begin
                failures++;
                $display("[TB] FAIL bp_drain idx=%0d got=%h want=%h", k, {wb_valid1, wb_data1}, {1'b1, drainExp[k]});
            end
        end
        tick();
        checks++;
        if ({wb_valid1, overflow1} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL bp_end got=%b want=01", {wb_valid1, overflow1});
        end
    endtask

    task automatic test_async_reset();
        for (int r = 0; r < 2; r++) begin
            for (int l = 0; l < 4; l++) applyStimulus(l, 6'd3, 32'h300 + 32'(l), 5'd2);
            tick();
        end
        clearInputs();
        checks++;
        if (wb_valid !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL areset_pre got=%b want=1111", wb_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wb_valid, wb_prf_we, lane_stall, overflow, wb_valid1, overflow1} !== 18'h0) begin
            failures++;
            $display("[TB] FAIL areset_flags got=%h want=0",
                     {wb_valid, wb_prf_we, lane_stall, overflow, wb_valid1, overflow1});
        end
        checks++;
        if ({wb_prn, wb_data, wb_rob} !== 172'h0) begin
            failures++;
            $display("[TB] FAIL areset_payload got=%h want=0", {wb_prn, wb_data, wb_rob});
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({wb_valid, wb_valid1} !== 5'b0) begin
                failures++;
                $display("[TB] FAIL areset_empty cycle=%0d got=%b want=00000", c, {wb_valid, wb_valid1});
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        pipe_flush = 1'b0;
        clearInputs();
        test_reset();
        test_single();
        test_contention();
        test_zero_prn();
        test_flush();
        test_backpressure();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog time=%0t limit=100000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the functional units and the physical register file / ROB completion ports. Accepts up to one completed execute result per FU lane per cycle, buffers each lane in a small FIFO, and drains up to `N_WB` results per cycle to the writeback ports with round-robin fairness across lanes. It is the consumer end of the execute-packet interface. It drives per-lane stall back to issue, and drives the writeback bus used for PRF writes, ROB completion and the LSQ/writeback bypass.

## Interface
Parameters:
- `N_IN`, 7, number of FU lanes (ALU0-3, MUL0, BRU0, AGU0)
- `N_WB`, 4, writeback ports per cycle
- `DEPTH`, 4, per-lane FIFO entries (power of 2, ≥2)
- `XLEN`, 32, result width
- `PRF_W`, 6, physical register number width
- `ROB_W`, 5, ROB index width

Ports:
- `clk` input 1: clock
- `rst_n` input 1: reset, asynchronous, active-low
- `pipe_flush` input 1: synchronous flush
- `in_valid` input `N_IN`: lane i has a completed result this cycle
- `in_prn` input `N_IN*PRF_W`: lane i destination PRN (0 = no register write)
- `in_data` input `N_IN*XLEN`: lane i result
- `in_rob` input `N_IN*ROB_W`: lane i ROB entry
- `lane_stall` output `N_IN`: lane i must not issue
- `wb_valid` output `N_WB`: port k carries a completion
- `wb_prf_we` output `N_WB`: port k writes the PRF
- `wb_prn` output `N_WB*PRF_W`
- `wb_data` output `N_WB*XLEN`
- `wb_rob` output `N_WB*ROB_W`
- `overflow` output 1: sticky error flag

## Operation
- **Storage.** One FIFO per lane, holding {prn, data, rob}. Each FIFO has a `$clog2(DEPTH)+1`-bit count and wrapping read/write pointers.
- **Push.** `in_valid[i]` pushes at the posedge. Entries with `in_prn==0` (stores, conditional branches) are still pushed, because the ROB needs completion.
- **Push to a full FIFO.** The entry is dropped and `overflow` is set. `overflow` stays set until reset; flush does not clear it.
- **Arbitration.** Combinational, over the FIFO heads.
  - Scan lanes `rr_ptr`, `rr_ptr+1`, … mod `N_IN`.
  - Grant the first `N_WB` non-empty lanes, at most one entry per lane per cycle.
  - Grant order maps to ports 0..N_WB-1. Unused ports get `wb_valid=0`.
- **Pointer update.** `rr_ptr` loads (last granted lane + 1) mod `N_IN`. It is unchanged if nothing is granted.
- **Same-cycle push and pop.** Simultaneous push and pop on one lane is legal. The count is unchanged, including when the FIFO is full.
- **Output registers.** Granted heads pop at the posedge and load the output registers. `wb_prf_we[k] = wb_valid[k] && wb_prn[k]!=0`, registered.
- **Stall.** `lane_stall[i] = count[i] >= DEPTH-1`, combinational from the registered count. This leaves one entry of slack for a result already in flight. The MUL lane gets the same signal; issue accounts for its 2-cycle pipe.
- **Flush.** `pipe_flush` at a posedge has priority over push and pop. It has these effects:
  - all counts and pointers go to 0;
  - `rr_ptr` goes to 0;
  - all `wb_valid` go to 0.
  - Inputs in the flush cycle are discarded.
- **Reset.** All outputs are 0: `wb_valid`, `wb_prf_we`, `wb_prn`, `wb_data`, `wb_rob`, `lane_stall`, `overflow`. FIFOs are empty and `rr_ptr` is 0.

## Timing
- **Latency.** A result presented in cycle T appears on a `wb_*` port in cycle T+2 if its lane FIFO is empty and the lane wins arbitration in T+1.
- **Throughput.** Sustained `N_WB` results per cycle. Each lane drains at most one entry per cycle.
- **Fairness.** A non-empty lane waits at most `ceil(N_IN/N_WB)` arbitration cycles before it is granted.
- **Stall timing.** `lane_stall` changes only at posedges, one cycle after the count change.
- **Reset.** Asynchronous: outputs go to 0 immediately on `rst_n` falling, including mid-burst. There is no recovery of in-flight data.
- **Wrap.** Pointers wrap modulo `DEPTH`. The count saturates at `DEPTH` only through the overflow-drop rule.

## Test plan
- **Single result.** Lane 0 pushes prn=5, data=0x1234, rob=3 in cycle 1. Expect `wb_valid[0]=1`, `wb_prf_we[0]=1`, prn 5, data 0x1234, rob 3 in cycle 3, and nothing else valid.
- **Contention and round-robin.** All 7 lanes push once in the same cycle with `rr_ptr=0`.
  - Cycle +2: lanes 0-3 on ports 0-3.
  - Cycle +3: lanes 4, 5, 6 on ports 0-2, with `wb_valid[3]=0`.
  - `rr_ptr` ends at 0.
- **Zero PRN.** Lane 6 pushes prn=0, rob=9. Expect `wb_valid=1`, `wb_prf_we=0`, rob 9.
- **Backpressure.** Set `N_WB=1` and hold lanes 0 and 1 pushing every cycle.
  - `lane_stall[0]` rises once `count[0]` reaches 3.
  - A continued push at `count=4` with no pop sets `overflow=1` and the entry never appears.
- **Flush mid-burst.** Fill lanes 0-2 with 2 entries each, then assert `pipe_flush` for one cycle.
  - Next cycle: all `wb_valid=0`, `lane_stall=0`.
  - A new push after the flush appears 2 cycles later on port 0.
- **Async reset.** Drop `rst_n` mid-cycle while `wb_valid=4'b1111`. Outputs go to 0 before the next edge, and the FIFOs are empty after release.
